pe_array_scheduler: RTL and testbench



---
 rtl/pe_array_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_pe_array_scheduler.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_scheduler.sv
// pe_array_scheduler: shares one 8x8 PE array among NUM_REQ job requesters.
// Round-robin grant, per-tile pe_valid/pe_done sequencing with a one-cycle
// gap between tiles, per-requester completion pulse and a timeout abort.
//
// Handshakes: req_ready[g] is a one-cycle Mealy accept pulse, asserted in IDLE
// in the same cycle req_valid[g] wins arbitration. The requester must hold
// req_valid and req_tiles until that pulse. pe_valid is held for a whole tile
// until pe_done arrives. pe_ready is not required for pe_valid to assert,
// because the array gates itself.
//
// Optional build macro PE_SCHED_PERF_EN adds the perf_busy_cycles and
// perf_tiles_done saturating counters.
module pe_array_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int TILE_CNT_W  = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*TILE_CNT_W-1:0]   req_tiles,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              cmp_valid,
   output logic                            cmp_error,
   output logic                            pe_valid,
   input  logic                            pe_ready,
   input  logic                            pe_done,
   output logic [TILE_CNT_W-1:0]           tile_idx,
   output logic [$clog2(NUM_REQ)-1:0]      owner_id,
   output logic                            busy,
   output logic [1:0]                      state_dbg
`ifdef PE_SCHED_PERF_EN
   ,
   output logic [31:0]                     perf_busy_cycles,
   output logic [31:0]                     perf_tiles_done
`endif
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int TO_W = $clog2(TIMEOUT_CYC);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_GAP      = 2'd2,
      S_COMPLETE = 2'd3
   } state_t;

   state_t                 state;
   logic [ID_W-1:0]        rr_ptr;
   logic [TILE_CNT_W-1:0]  tiles_reg;
   logic [TO_W-1:0]        to_cnt;
   logic                   grant_any;
   logic [ID_W-1:0]        grant_id;
   logic [TILE_CNT_W-1:0]  grant_tiles;
   logic [TILE_CNT_W-1:0]  last_idx;
   logic [ID_W-1:0]        rr_next;

   // The array throttles itself, so pe_ready only stretches time spent in RUN.
   logic unused_pe_ready;
   assign unused_pe_ready = pe_ready;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
      logic [NUM_REQ-1:0] v;
      v = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   assign state_dbg   = state;
   assign grant_tiles = req_tiles[grant_id*TILE_CNT_W +: TILE_CNT_W];
   assign last_idx    = tiles_reg - 1'b1;
   assign rr_next     = (owner_id == ID_LAST) ? '0 : owner_id + 1'b1;

   // Round-robin search: first requesting index at or above rr_ptr, with wrap.
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_id  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = ID_W'(idx);
         end
      end
   end

   // Mealy accept pulse; forced low while reset is asserted so every output reads 0.
   always_comb begin
      req_ready = '0;
      if (rst_n && state == S_IDLE && grant_any) req_ready = onehot(grant_id);
   end

   // Main FSM with registered pe_valid, busy and completion outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         owner_id  <= '0;
         tile_idx  <= '0;
         tiles_reg <= '0;
         to_cnt    <= '0;
         pe_valid  <= 1'b0;
         busy      <= 1'b0;
         cmp_valid <= '0;
         cmp_error <= 1'b0;
      end else begin
         cmp_valid <= '0;
         cmp_error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  owner_id  <= grant_id;
                  tiles_reg <= grant_tiles;
                  tile_idx  <= '0;
                  busy      <= 1'b1;
                  if (grant_tiles == '0) begin
                     state     <= S_COMPLETE;
                     cmp_valid <= onehot(grant_id);
                  end else begin
                     state    <= S_RUN;
                     pe_valid <= 1'b1;
                     to_cnt   <= '0;
                  end
               end
            end
            S_RUN: begin
               to_cnt <= to_cnt + 1'b1;
               // pe_done takes priority over a coincident timeout.
               if (pe_done) begin
                  pe_valid <= 1'b0;
                  if (tile_idx == last_idx) begin
                     state     <= S_COMPLETE;
                     cmp_valid <= onehot(owner_id);
                  end else begin
                     tile_idx <= tile_idx + 1'b1;
                     state    <= S_GAP;
                  end
               end else if (to_cnt == TO_LAST) begin
                  pe_valid  <= 1'b0;
                  state     <= S_COMPLETE;
                  cmp_valid <= onehot(owner_id);
                  cmp_error <= 1'b1;
               end
            end
            S_GAP: begin
               state    <= S_RUN;
               pe_valid <= 1'b1;
               to_cnt   <= '0;
            end
            S_COMPLETE: begin
               rr_ptr <= rr_next;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef PE_SCHED_PERF_EN
   // Saturating activity counters: busy cycles and tiles accepted in RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_cycles <= '0;
         perf_tiles_done  <= '0;
      end else begin
         if (busy && perf_busy_cycles != 32'hFFFF_FFFF)
            perf_busy_cycles <= perf_busy_cycles + 1'b1;
         if (state == S_RUN && pe_done && perf_tiles_done != 32'hFFFF_FFFF)
            perf_tiles_done <= perf_tiles_done + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pe_array_scheduler.sv
// tb_pe_array_scheduler: directed bench for pe_array_scheduler (TIMEOUT_CYC=16).
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
module tb_pe_array_scheduler;

   localparam int NUM_REQ     = 4;
   localparam int TILE_CNT_W  = 8;
   localparam int TIMEOUT_CYC = 16;

   logic                          clk;
   logic                          rst_n;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*TILE_CNT_W-1:0] req_tiles;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            cmp_valid;
   logic                          cmp_error;
   logic                          pe_valid;
   logic                          pe_ready;
   logic                          pe_done;
   logic [TILE_CNT_W-1:0]         tile_idx;
   logic [1:0]                    owner_id;
   logic                          busy;
   logic [1:0]                    state_dbg;
`ifdef PE_SCHED_PERF_EN
   logic [31:0]                   perf_busy_cycles;
   logic [31:0]                   perf_tiles_done;
`endif

   int checks = 0;
   int errors = 0;

   pe_array_scheduler #(
      .NUM_REQ(NUM_REQ),
      .TILE_CNT_W(TILE_CNT_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_tiles(req_tiles),
      .req_ready(req_ready),
      .cmp_valid(cmp_valid),
      .cmp_error(cmp_error),
      .pe_valid(pe_valid),
      .pe_ready(pe_ready),
      .pe_done(pe_done),
      .tile_idx(tile_idx),
      .owner_id(owner_id),
      .busy(busy),
      .state_dbg(state_dbg)
`ifdef PE_SCHED_PERF_EN
      ,
      .perf_busy_cycles(perf_busy_cycles),
      .perf_tiles_done(perf_tiles_done)
`endif
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_tiles = '0;
      pe_ready  = 1'b1;
      pe_done   = 1'b0;
      repeat (2) @(posedge clk);
      settle();
      checks++;
      if ({req_ready, cmp_valid, cmp_error, pe_valid, tile_idx, owner_id, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rr=%b cv=%b ce=%b pv=%b ti=%0d own=%0d busy=%b exp all 0",
                  req_ready, cmp_valid, cmp_error, pe_valid, tile_idx, owner_id, busy);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      for (int j = 0; j < 5; j++) begin
         step();
         req_valid = 4'b1111;
         req_tiles = {8'd1, 8'd1, 8'd1, 8'd1};
         pe_done   = 1'b0;
         settle();
         checks++;
         if (req_ready !== 4'(1 << order[j])) begin
            errors++;
            $display("FAIL rr_grant%0d got %b exp %b", j, req_ready, 4'(1 << order[j]));
         end
         step();
         pe_done = 1'b1;
         settle();
         checks++;
         if ({pe_valid, owner_id, tile_idx} !== {1'b1, 2'(order[j]), 8'd0}) begin
            errors++;
            $display("FAIL rr_run%0d got pv=%b own=%0d ti=%0d exp pv=1 own=%0d ti=0",
                     j, pe_valid, owner_id, tile_idx, order[j]);
         end
         step();
         pe_done = 1'b0;
         settle();
         checks++;
         if ({cmp_valid, cmp_error, pe_valid} !== {4'(1 << order[j]), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rr_cmp%0d got cv=%b ce=%b pv=%b exp cv=%b ce=0 pv=0",
                     j, cmp_valid, cmp_error, pe_valid, 4'(1 << order[j]));
         end
      end
      step();
      req_valid = '0;
      settle();
      checks++;
      if ({busy, req_ready} !== 5'b0) begin
         errors++;
         $display("FAIL rr_idle got busy=%b rr=%b exp 0 0000", busy, req_ready);
      end
   endtask

   task automatic test_single_job();
      step();
      req_valid = 4'b0010;
      req_tiles = {8'd0, 8'd0, 8'd3, 8'd0};
      settle();
      checks++;
      if ({req_ready, pe_valid} !== {4'b0010, 1'b0}) begin
         errors++;
         $display("FAIL single_grant got rr=%b pv=%b exp 0010 0", req_ready, pe_valid);
      end
      for (int t = 0; t < 3; t++) begin
         for (int k = 1; k <= 12; k++) begin
            step();
            req_valid = '0;
            pe_done   = (k == 12);
            settle();
            checks++;
            if ({pe_valid, tile_idx, owner_id, cmp_valid} !== {1'b1, 8'(t), 2'd1, 4'b0}) begin
               errors++;
               $display("FAIL single_run t%0d k%0d got pv=%b ti=%0d own=%0d cv=%b exp 1 %0d 1 0000",
                        t, k, pe_valid, tile_idx, owner_id, cmp_valid, t);
            end
         end
         step();
         pe_done = 1'b0;
         settle();
         checks++;
         if (t < 2) begin
            if ({pe_valid, busy, cmp_valid, tile_idx} !== {1'b0, 1'b1, 4'b0, 8'(t + 1)}) begin
               errors++;
               $display("FAIL single_gap t%0d got pv=%b busy=%b cv=%b ti=%0d exp 0 1 0000 %0d",
                        t, pe_valid, busy, cmp_valid, tile_idx, t + 1);
            end
         end else begin
            if ({cmp_valid, cmp_error, pe_valid, tile_idx} !== {4'b0010, 1'b0, 1'b0, 8'd2}) begin
               errors++;
               $display("FAIL single_cmp got cv=%b ce=%b pv=%b ti=%0d exp 0010 0 0 2",
                        cmp_valid, cmp_error, pe_valid, tile_idx);
            end
         end
      end
      step();
      settle();
      checks++;
      if ({busy, cmp_valid, tile_idx} !== {1'b0, 4'b0, 8'd2}) begin
         errors++;
         $display("FAIL single_idle got busy=%b cv=%b ti=%0d exp 0 0000 2", busy, cmp_valid, tile_idx);
      end
   endtask

   task automatic test_zero_tiles();
      step();
      req_valid = 4'b0100;
      req_tiles = '0;
      settle();
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL zero_grant got %b exp 0100", req_ready);
      end
      step();
      req_valid = '0;
      settle();
      checks++;
      if ({cmp_valid, cmp_error, pe_valid, busy} !== {4'b0100, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL zero_cmp got cv=%b ce=%b pv=%b busy=%b exp 0100 0 0 1",
                  cmp_valid, cmp_error, pe_valid, busy);
      end
      step();
      settle();
      checks++;
      if ({busy, pe_valid, cmp_valid} !== 6'b0) begin
         errors++;
         $display("FAIL zero_idle got busy=%b pv=%b cv=%b exp 0 0 0000", busy, pe_valid, cmp_valid);
      end
   endtask

   task automatic test_timeout();
      int pv_cnt;
      // Requester 3 with the array stalled: no pe_done, pe_ready low.
      step();
      req_valid = 4'b1000;
      req_tiles = {8'd2, 8'd0, 8'd0, 8'd0};
      pe_ready  = 1'b0;
      settle();
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL to_grant got %b exp 1000", req_ready);
      end
      pv_cnt = 0;
      for (int k = 0; k < TIMEOUT_CYC; k++) begin
         step();
         req_valid = '0;
         settle();
         if (pe_valid === 1'b1 && cmp_valid === 4'b0) pv_cnt++;
      end
      checks++;
      if (pv_cnt != 16) begin
         errors++;
         $display("FAIL to_run_len got %0d exp 16", pv_cnt);
      end
      step();
      settle();
      checks++;
      if ({cmp_valid, cmp_error, pe_valid, busy} !== {4'b1000, 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL to_cmp got cv=%b ce=%b pv=%b busy=%b exp 1000 1 0 1",
                  cmp_valid, cmp_error, pe_valid, busy);
      end
      step();
      pe_ready = 1'b1;
      settle();
      checks++;
      if ({busy, cmp_valid, cmp_error} !== 6'b0) begin
         errors++;
         $display("FAIL to_idle got busy=%b cv=%b ce=%b exp 0 0000 0", busy, cmp_valid, cmp_error);
      end
      // Requester 0: pe_done lands on the 16th RUN cycle, which must beat the timeout.
      step();
      req_valid = 4'b0001;
      req_tiles = {8'd0, 8'd0, 8'd0, 8'd2};
      settle();
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL coin_grant got %b exp 0001", req_ready);
      end
      for (int k = 1; k <= TIMEOUT_CYC; k++) begin
         step();
         req_valid = '0;
         pe_done   = (k == TIMEOUT_CYC);
         settle();
      end
      step();
      pe_done = 1'b0;
      settle();
      checks++;
      if ({pe_valid, cmp_valid, cmp_error, tile_idx} !== {1'b0, 4'b0, 1'b0, 8'd1}) begin
         errors++;
         $display("FAIL coin_gap got pv=%b cv=%b ce=%b ti=%0d exp 0 0000 0 1",
                  pe_valid, cmp_valid, cmp_error, tile_idx);
      end
      step();
      pe_done = 1'b1;
      settle();
      checks++;
      if ({pe_valid, tile_idx} !== {1'b1, 8'd1}) begin
         errors++;
         $display("FAIL coin_run2 got pv=%b ti=%0d exp 1 1", pe_valid, tile_idx);
      end
      step();
      pe_done = 1'b0;
      settle();
      checks++;
      if ({cmp_valid, cmp_error} !== {4'b0001, 1'b0}) begin
         errors++;
         $display("FAIL coin_cmp got cv=%b ce=%b exp 0001 0", cmp_valid, cmp_error);
      end
      step();
      settle();
   endtask

   task automatic test_reset_mid_job();
      step();
      req_valid = 4'b0100;
      req_tiles = {8'd0, 8'd4, 8'd0, 8'd0};
      settle();
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL mid_grant got %b exp 0100", req_ready);
      end
      step();
      req_valid = '0;
      pe_done   = 1'b0;
      step();
      pe_done = 1'b1;
      step();
      pe_done = 1'b0;
      step();
      settle();
      checks++;
      if ({pe_valid, tile_idx} !== {1'b1, 8'd1}) begin
         errors++;
         $display("FAIL mid_tile1 got pv=%b ti=%0d exp 1 1", pe_valid, tile_idx);
      end
      #2;
      rst_n     = 1'b0;
      req_valid = 4'b1001;
      req_tiles = {8'd1, 8'd0, 8'd0, 8'd1};
      #1;
      checks++;
      if ({req_ready, cmp_valid, cmp_error, pe_valid, tile_idx, owner_id, busy} !== '0) begin
         errors++;
         $display("FAIL mid_reset got rr=%b cv=%b ce=%b pv=%b ti=%0d own=%0d busy=%b exp all 0",
                  req_ready, cmp_valid, cmp_error, pe_valid, tile_idx, owner_id, busy);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         settle();
         checks++;
         if ({cmp_valid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL mid_held%0d got cv=%b busy=%b exp 0000 0", k, cmp_valid, busy);
         end
      end
      step();
      rst_n = 1'b1;
      settle();
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL mid_regrant got %b exp 0001", req_ready);
      end
      step();
      req_valid = '0;
      pe_done   = 1'b1;
      settle();
      checks++;
      if ({pe_valid, owner_id} !== {1'b1, 2'd0}) begin
         errors++;
         $display("FAIL mid_run got pv=%b own=%0d exp 1 0", pe_valid, owner_id);
      end
      step();
      pe_done = 1'b0;
      settle();
      checks++;
      if ({cmp_valid, cmp_error} !== {4'b0001, 1'b0}) begin
         errors++;
         $display("FAIL mid_cmp got cv=%b ce=%b exp 0001 0", cmp_valid, cmp_error);
      end
      step();
      settle();
   endtask

`ifdef PE_SCHED_PERF_EN
   task automatic test_perf();
      int busy_cnt;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      busy_cnt = 0;
      // Two 3-tile jobs, pe_done on the 2nd RUN cycle: 3*2 RUN + 2 GAP + 1 COMPLETE = 9 busy each.
      for (int j = 0; j < 2; j++) begin
         step();
         req_valid = (j == 0) ? 4'b0010 : 4'b0100;
         req_tiles = {8'd0, 8'd3, 8'd3, 8'd0};
         settle();
         if (busy === 1'b1) busy_cnt++;
         for (int c = 0; c < 9; c++) begin
            step();
            req_valid = '0;
            pe_done   = (c == 1) || (c == 4) || (c == 7);
            settle();
            if (busy === 1'b1) busy_cnt++;
         end
         step();
         pe_done = 1'b0;
         settle();
         if (busy === 1'b1) busy_cnt++;
      end
      checks++;
      if (perf_tiles_done !== 32'd6) begin
         errors++;
         $display("FAIL perf_tiles got %0d exp 6", perf_tiles_done);
      end
      checks++;
      if (perf_busy_cycles !== 32'(busy_cnt) || busy_cnt != 18) begin
         errors++;
         $display("FAIL perf_busy got %0d exp %0d (observed busy, 18 nominal)", perf_busy_cycles, busy_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_single_job();
      test_zero_tiles();
      test_timeout();
      test_reset_mid_job();
`ifdef PE_SCHED_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
